rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Owns the register-file write side: arbitrates two writeback requesters (ALU result, memory load) onto the single write path (data, Laddr, RFLwrite, RFHwrite).
- Also runs an init sequence that zeroes every register after boot or on command.
- Outputs are registered on posedge clk, so they are stable when the register file samples them at negedge clk.

Parameters:
- DW, 16, register data width; must be even, split into low and high byte lanes of DW/2 each.
- AW, 2, register address width.
- NREG, 4, number of registers cleared by the init sequence; NREG <= 2**AW.

Ports:
- clk  in  1  system clock, posedge logic.
- rst_n  in  1  asynchronous active-low reset.
- r0_valid  in  1  requester 0 (ALU) write request.
- r0_addr  in  AW  requester 0 target register.
- r0_data  in  DW  requester 0 write data.
- r0_be  in  2  requester 0 byte enables, {hi,lo}.
- r0_ready  out  1  requester 0 accepted this cycle.
- r1_valid, r1_addr, r1_data, r1_be, r1_ready  same widths and meaning for requester 1 (memory).
- init_start  in  1  single-cycle pulse; starts the clear sequence.
- init_done  out  1  single-cycle pulse when the clear sequence finishes.
- busy  out  1  high while in INIT.
- rf_data  out  DW  to register file data input.
- rf_addr  out  AW  to register file write/left address.
- rf_wr_lo  out  1  to RFLwrite.
- rf_wr_hi  out  1  to RFHwrite.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; rf_data=0, rf_addr=0, rf_wr_lo=0, rf_wr_hi=0.
  - init_done=0, busy=0, init counter=0.
  - last_grant=1, so requester 0 wins the first contention.
- FSM states:
  - IDLE -> INIT when init_start=1.
  - INIT -> IDLE after the write to register NREG-1 has issued.
- IDLE arbitration (ready outputs are combinational):
  - If init_start=1: both ready=0. Init has priority over a simultaneous request.
  - Else, only one valid: that requester gets ready=1.
  - Else, both valid: grant the requester not equal to last_grant (round robin).
  - A transfer is valid&ready. On a transfer, last_grant <= granted index.
  - Next posedge after a transfer: rf_addr <= addr, rf_data <= data, rf_wr_lo <= be[0], rf_wr_hi <= be[1]. Latency is 1 cycle from acceptance to strobe.
  - Cycles with no transfer: rf_wr_lo=rf_wr_hi=0. rf_data/rf_addr hold their last value.
  - A request with be=00 is still accepted and consumes its grant, but produces no strobes.
  - Each strobe is high for exactly one cycle per accepted request. Back-to-back acceptances produce strobes on consecutive cycles.
- INIT:
  - Both ready=0; busy=1 from the cycle after init_start.
  - Each cycle, cnt = 0..NREG-1: rf_addr <= cnt, rf_data <= 0, rf_wr_lo <= 1, rf_wr_hi <= 1.
  - Exactly NREG write cycles.
  - init_done pulses 1 cycle in the cycle after the last write strobe; the FSM returns to IDLE that same cycle.
  - busy=0 in that cycle; requests may be accepted in that cycle.
  - init_start during INIT is ignored; the counter is not restarted.
  - last_grant is unchanged by INIT.
- Requesters must hold valid/addr/data/be stable until ready. The arbiter never drops an accepted request.
- rst_n asserted mid-INIT or mid-transfer aborts immediately:
  - All strobes go to 0 asynchronously.
  - No init_done is generated.
  - A partially cleared register file is acceptable.

Test Plan:
- Reset then idle -> all outputs 0. r0 alone: addr=2, data=16'hA55A, be=11 -> r0_ready=1 same cycle; next cycle rf_addr=2, rf_data=A55A, rf_wr_lo=rf_wr_hi=1 for exactly one cycle.
- Both valid continuously (r0 data 16'h1111 addr1, r1 data 16'h2222 addr3), 4 cycles -> grants alternate r0, r1, r0, r1; strobed data alternates 1111, 2222, 1111, 2222.
- Byte lanes: r1 be=01 data 16'hBEEF -> only rf_wr_lo=1. be=10 -> only rf_wr_hi=1. be=00 -> r1_ready=1 and no strobe.
- init_start in the same cycle as r0_valid -> r0_ready=0. Writes of 0x0000 with both strobes to addr 0, 1, 2, 3 on 4 consecutive cycles; busy=1 throughout. init_done pulses the next cycle; r0 is accepted in that cycle.
- Second init_start pulse during INIT -> ignored; still exactly 4 writes and one init_done.
- rst_n low at INIT cnt=1 -> strobes drop immediately; after release: IDLE, busy=0, no init_done; next contention grants r0 first.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-side owner: round-robin arbitration between the ALU (r0)
// and memory (r1) writeback requesters, plus a clear sequence that writes zero
// to every register. All write-path outputs are registered on posedge clk so
// they are stable when the register file samples them on negedge clk.
//
// Handshake: a requester holds valid/addr/data/be stable until it sees ready.
// ready is combinational and is only raised in IDLE when no init_start is
// present; a transfer is valid & ready, and its strobes appear on the write
// path in the following cycle for exactly one cycle.
module rf_write_arbiter #(
   parameter int DW   = 16,  // even: low and high byte lanes of DW/2 each
   parameter int AW   = 2,
   parameter int NREG = 4    // NREG <= 2**AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          r0_valid,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_data,
   input  logic [1:0]    r0_be,
   output logic          r0_ready,
   input  logic          r1_valid,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_data,
   input  logic [1:0]    r1_be,
   output logic          r1_ready,
   input  logic          init_start,
   output logic          init_done,
   output logic          busy,
   output logic [DW-1:0] rf_data,
   output logic [AW-1:0] rf_addr,
   output logic          rf_wr_lo,
   output logic          rf_wr_hi
);

   typedef enum logic {IDLE, INIT} state_t;

   // The counter runs one past the last register: the extra INIT cycle is the
   // one in which the final strobe is visible on the write path.
   localparam int CW = $clog2(NREG + 1);
   localparam logic [CW-1:0] CNT_END = CW'(NREG);

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          last_grant;
   logic          grant0, grant1;
   logic          issue_init;
   logic          finish;

   // Combinational arbitration; grants are only possible in IDLE without a
   // simultaneous init_start. On contention, the requester not served last wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE && !init_start) begin
         if (r0_valid && r1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
         end else begin
            grant0 = r0_valid;
            grant1 = r1_valid;
         end
      end
   end

   assign r0_ready = grant0;
   assign r1_ready = grant1;
   assign busy     = (state == INIT);

   // Next-state logic for the clear sequence.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      issue_init = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (init_start) begin
               state_nx = INIT;
               cnt_nx   = '0;
            end
         end
         INIT: begin
            if (cnt == CNT_END) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               finish   = 1'b1;
            end else begin
               issue_init = 1'b1;
               cnt_nx     = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, counter, round-robin pointer and the registered write path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         init_done  <= 1'b0;
         rf_data    <= '0;
         rf_addr    <= '0;
         rf_wr_lo   <= 1'b0;
         rf_wr_hi   <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         init_done <= finish;
         rf_wr_lo  <= 1'b0;
         rf_wr_hi  <= 1'b0;
         if (issue_init) begin
            rf_addr  <= AW'(cnt);
            rf_data  <= '0;
            rf_wr_lo <= 1'b1;
            rf_wr_hi <= 1'b1;
         end else if (grant0) begin
            rf_addr    <= r0_addr;
            rf_data    <= r0_data;
            rf_wr_lo   <= r0_be[0];
            rf_wr_hi   <= r0_be[1];
            last_grant <= 1'b0;
         end else if (grant1) begin
            rf_addr    <= r1_addr;
            rf_data    <= r1_data;
            rf_wr_lo   <= r1_be[0];
            rf_wr_hi   <= r1_be[1];
            last_grant <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: single-cycle vector table for
// arbitration and byte lanes, then hand-written init / reset sequences.
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_valid, r1_valid;
   logic [1:0]  r0_addr, r1_addr;
   logic [15:0] r0_data, r1_data;
   logic [1:0]  r0_be, r1_be;
   logic        r0_ready, r1_ready;
   logic        init_start, init_done, busy;
   logic [15:0] rf_data;
   logic [1:0]  rf_addr;
   logic        rf_wr_lo, rf_wr_hi;

   int errors = 0;
   int checks = 0;
   logic [1:0] exp_q[$];

   rf_write_arbiter #(.DW(16), .AW(2), .NREG(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_be(r0_be), .r0_ready(r0_ready),
      .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_be(r1_be), .r1_ready(r1_ready),
      .init_start(init_start), .init_done(init_done), .busy(busy),
      .rf_data(rf_data), .rf_addr(rf_addr), .rf_wr_lo(rf_wr_lo), .rf_wr_hi(rf_wr_hi)
   );

   // clock / reset
   always #5 clk = ~clk;

   typedef struct {
      logic        r0v;
      logic [1:0]  r0a;
      logic [15:0] r0d;
      logic [1:0]  r0b;
      logic        r1v;
      logic [1:0]  r1a;
      logic [15:0] r1d;
      logic [1:0]  r1b;
      logic        e_rdy0;
      logic        e_rdy1;
      logic [1:0]  e_addr;
      logic [15:0] e_data;
      logic        e_lo;
      logic        e_hi;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(logic r0v, logic [1:0] r0a, logic [15:0] r0d, logic [1:0] r0b,
                               logic r1v, logic [1:0] r1a, logic [15:0] r1d, logic [1:0] r1b,
                               logic e_rdy0, logic e_rdy1, logic [1:0] e_addr,
                               logic [15:0] e_data, logic e_lo, logic e_hi);
      vec_t v;
      v.r0v = r0v; v.r0a = r0a; v.r0d = r0d; v.r0b = r0b;
      v.r1v = r1v; v.r1a = r1a; v.r1d = r1d; v.r1b = r1b;
      v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_addr = e_addr;
      v.e_data = e_data; v.e_lo = e_lo; v.e_hi = e_hi;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic clear_inputs();
      r0_valid = 1'b0; r0_addr = '0; r0_data = '0; r0_be = '0;
      r1_valid = 1'b0; r1_addr = '0; r1_data = '0; r1_be = '0;
      init_start = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nwr;
      int ndone;
      logic [1:0] ea;

      // Both-valid contention starts right after reset, so r0 must win first.
      vecs[0]  = mk(0, 0, 16'h0000, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000, 0, 0);
      vecs[1]  = mk(1, 1, 16'h1111, 2'b11, 1, 3, 16'h2222, 2'b11, 1, 0, 1, 16'h1111, 1, 1);
      vecs[2]  = mk(1, 1, 16'h1111, 2'b11, 1, 3, 16'h2222, 2'b11, 0, 1, 3, 16'h2222, 1, 1);
      vecs[3]  = mk(1, 1, 16'h1111, 2'b11, 1, 3, 16'h2222, 2'b11, 1, 0, 1, 16'h1111, 1, 1);
      vecs[4]  = mk(1, 1, 16'h1111, 2'b11, 1, 3, 16'h2222, 2'b11, 0, 1, 3, 16'h2222, 1, 1);
      vecs[5]  = mk(1, 2, 16'hA55A, 2'b11, 0, 0, 16'h0000, 2'b00, 1, 0, 2, 16'hA55A, 1, 1);
      vecs[6]  = mk(0, 0, 16'h0000, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0, 2, 16'hA55A, 0, 0);
      vecs[7]  = mk(0, 0, 16'h0000, 2'b00, 1, 1, 16'hBEEF, 2'b01, 0, 1, 1, 16'hBEEF, 1, 0);
      vecs[8]  = mk(0, 0, 16'h0000, 2'b00, 1, 2, 16'hBEEF, 2'b10, 0, 1, 2, 16'hBEEF, 0, 1);
      vecs[9]  = mk(0, 0, 16'h0000, 2'b00, 1, 2, 16'hBEEF, 2'b00, 0, 1, 2, 16'hBEEF, 0, 0);
      vecs[10] = mk(0, 0, 16'h0000, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0, 2, 16'hBEEF, 0, 0);
      vecs[11] = mk(1, 0, 16'h1234, 2'b11, 1, 1, 16'h5678, 2'b11, 1, 0, 0, 16'h1234, 1, 1);
      vecs[12] = mk(1, 3, 16'h0F0F, 2'b01, 0, 0, 16'h0000, 2'b00, 1, 0, 3, 16'h0F0F, 1, 0);

      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      chk("reset rf_data", 32'(rf_data), 32'h0);
      chk("reset rf_addr", 32'(rf_addr), 32'h0);
      chk("reset strobes", {30'b0, rf_wr_hi, rf_wr_lo}, 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset init_done", 32'(init_done), 32'h0);
      chk("reset readies", {30'b0, r1_ready, r0_ready}, 32'h0);

      // table: one accepted-or-not cycle per vector, write path checked next cycle
      for (int i = 0; i < 13; i++) begin
         r0_valid = vecs[i].r0v; r0_addr = vecs[i].r0a; r0_data = vecs[i].r0d; r0_be = vecs[i].r0b;
         r1_valid = vecs[i].r1v; r1_addr = vecs[i].r1a; r1_data = vecs[i].r1d; r1_be = vecs[i].r1b;
         #1;
         chk($sformatf("v%0d r0_ready", i), 32'(r0_ready), 32'(vecs[i].e_rdy0));
         chk($sformatf("v%0d r1_ready", i), 32'(r1_ready), 32'(vecs[i].e_rdy1));
         next_cycle();
         chk($sformatf("v%0d rf_addr", i), 32'(rf_addr), 32'(vecs[i].e_addr));
         chk($sformatf("v%0d rf_data", i), 32'(rf_data), 32'(vecs[i].e_data));
         chk($sformatf("v%0d rf_wr_lo", i), 32'(rf_wr_lo), 32'(vecs[i].e_lo));
         chk($sformatf("v%0d rf_wr_hi", i), 32'(rf_wr_hi), 32'(vecs[i].e_hi));
      end
      clear_inputs();
      next_cycle();

      // init_start with simultaneous r0 request: init wins, r0 served after init_done
      r0_valid = 1'b1; r0_addr = 2'd1; r0_data = 16'h7777; r0_be = 2'b11;
      init_start = 1'b1;
      #1;
      chk("init vs r0 r0_ready", 32'(r0_ready), 32'h0);
      chk("init vs r0 r1_ready", 32'(r1_ready), 32'h0);
      next_cycle();
      init_start = 1'b0;
      #1;
      chk("init first busy", 32'(busy), 32'h1);
      chk("init first strobe", {30'b0, rf_wr_hi, rf_wr_lo}, 32'h0);
      chk("init first r0_ready", 32'(r0_ready), 32'h0);
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         chk($sformatf("init w%0d addr", i), 32'(rf_addr), 32'(i));
         chk($sformatf("init w%0d data", i), 32'(rf_data), 32'h0);
         chk($sformatf("init w%0d strobes", i), {30'b0, rf_wr_hi, rf_wr_lo}, 32'h3);
         chk($sformatf("init w%0d busy", i), 32'(busy), 32'h1);
         chk($sformatf("init w%0d init_done", i), 32'(init_done), 32'h0);
         chk($sformatf("init w%0d r0_ready", i), 32'(r0_ready), 32'h0);
      end
      next_cycle();
      chk("init_done pulse", 32'(init_done), 32'h1);
      chk("init end busy", 32'(busy), 32'h0);
      chk("init end strobes", {30'b0, rf_wr_hi, rf_wr_lo}, 32'h0);
      chk("init end r0_ready", 32'(r0_ready), 32'h1);
      next_cycle();
      r0_valid = 1'b0;
      chk("init_done one cycle", 32'(init_done), 32'h0);
      chk("post-init r0 addr", 32'(rf_addr), 32'h1);
      chk("post-init r0 data", 32'(rf_data), 32'h7777);
      chk("post-init r0 strobes", {30'b0, rf_wr_hi, rf_wr_lo}, 32'h3);
      clear_inputs();
      next_cycle();

      // second init_start during INIT is ignored: exactly 4 writes, one done
      for (int a = 0; a < 4; a++) exp_q.push_back(2'(a));
      nwr = 0;
      ndone = 0;
      init_start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         next_cycle();
         if (rf_wr_lo || rf_wr_hi) begin
            nwr++;
            if (exp_q.size() == 0) begin
               chk("re-init extra write", 32'(rf_addr), 32'hFFFF_FFFF);
            end else begin
               ea = exp_q.pop_front();
               chk("re-init write addr", 32'(rf_addr), 32'(ea));
               chk("re-init write data", 32'(rf_data), 32'h0);
            end
         end
         if (init_done) ndone++;
         init_start = (k == 2);
      end
      chk("re-init write count", 32'(nwr), 32'h4);
      chk("re-init done count", 32'(ndone), 32'h1);
      chk("re-init pending writes", 32'(exp_q.size()), 32'h0);

      // reset in the middle of INIT (cnt=1, first clear strobe visible)
      init_start = 1'b1;
      next_cycle();
      init_start = 1'b0;
      next_cycle();
      chk("pre-reset strobe lo", 32'(rf_wr_lo), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("async reset strobes", {30'b0, rf_wr_hi, rf_wr_lo}, 32'h0);
      chk("async reset busy", 32'(busy), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      nwr = 0;
      ndone = 0;
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         if (rf_wr_lo || rf_wr_hi) nwr++;
         if (init_done || busy) ndone++;
      end
      chk("post-reset strobes", 32'(nwr), 32'h0);
      chk("post-reset done/busy", 32'(ndone), 32'h0);
      r0_valid = 1'b1; r0_addr = 2'd2; r0_data = 16'hCAFE; r0_be = 2'b11;
      r1_valid = 1'b1; r1_addr = 2'd3; r1_data = 16'hD00D; r1_be = 2'b11;
      #1;
      chk("post-reset contention r0_ready", 32'(r0_ready), 32'h1);
      chk("post-reset contention r1_ready", 32'(r1_ready), 32'h0);
      next_cycle();
      clear_inputs();
      chk("post-reset grant data", 32'(rf_data), 32'hCAFE);
      chk("post-reset grant addr", 32'(rf_addr), 32'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // absolute time bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule
